// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1/8E1 UART receiver with mid-bit sampling, parity/framing checks and break hold-off
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_pin,
  input  logic       parity_enable,
  output logic [7:0] rx_data,
  output logic       data_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_e;

  logic             sync1_q, sync2_q, prev_q;
  logic [1:0]       warm_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_en_q, par_en_d;
  logic             par_flag_q, par_flag_d;
  logic             frm_flag_q, frm_flag_d;
  logic             done_q, done_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             data_ready_q, data_ready_d;
  logic             parity_err_q, parity_err_d;
  logic             frame_err_q, frame_err_d;
  logic             rx_s, fall;

  assign rx_s = sync2_q;
  // The synchronizer resets to 1, so edges are ignored until real line samples reach prev_q.
  assign fall = (warm_q == 2'd3) && prev_q && !rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      warm_q       <= 2'd0;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      par_flag_q   <= 1'b0;
      frm_flag_q   <= 1'b0;
      done_q       <= 1'b0;
      rx_data_q    <= 8'h00;
      data_ready_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync1_q      <= rx_pin;
      sync2_q      <= sync1_q;
      prev_q       <= rx_s;
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      par_en_q     <= par_en_d;
      par_flag_q   <= par_flag_d;
      frm_flag_q   <= frm_flag_d;
      done_q       <= done_d;
      rx_data_q    <= rx_data_d;
      data_ready_q <= data_ready_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    par_en_d     = par_en_q;
    par_flag_d   = par_flag_q;
    frm_flag_d   = frm_flag_q;
    done_d       = done_q;
    rx_data_d    = rx_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    data_ready_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d    = S_DATA;
            bit_idx_d  = '0;
            par_en_d   = parity_enable;
            par_flag_d = 1'b0;
            frm_flag_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = par_en_q ? S_PARITY : S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d      = '0;
          par_flag_d = rx_s ^ (^shift_q);
          state_d    = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        // done_q marks the cycle after the stop sample, when results are published.
        if (done_q) begin
          done_d       = 1'b0;
          rx_data_d    = shift_q;
          parity_err_d = par_flag_q;
          frame_err_d  = frm_flag_q;
          data_ready_d = 1'b1;
          state_d      = rx_s ? S_IDLE : S_BREAK;
        end else if (cnt_q == FULL_M1) begin
          cnt_d      = '0;
          frm_flag_d = !rx_s;
          done_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_data    = rx_data_q;
  assign data_ready = data_ready_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign rx_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized and directed bench for uart_rx against a frame-level reference queue
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_pin;
  logic       parity_enable;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulse_cnt = 0;
  logic dr_prev = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         due;
  } frame_t;

  frame_t exp_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_pin       (rx_pin),
    .parity_enable(parity_enable),
    .rx_data      (rx_data),
    .data_ready   (data_ready),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Reference: each frame's result appears a fixed time after its start bit is driven:
  // 2 sync flops + 1 edge detect + half bit + data/parity/stop bits + 1 output register.
  always @(negedge clk) begin
    if (data_ready) begin
      frame_t f;
      check("pulse_width", {31'd0, dr_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        check("spurious_ready", 32'd1, 32'd0);
      end else begin
        f = exp_q.pop_front();
        check("rx_data", {24'd0, rx_data}, {24'd0, f.data});
        check("parity_err", {31'd0, parity_err}, {31'd0, f.perr});
        check("frame_err", {31'd0, frame_err}, {31'd0, f.ferr});
        check("latency", cyc, f.due);
      end
      pulse_cnt <= pulse_cnt + 1;
    end
    dr_prev <= data_ready;
  end

  // Called and returns on a falling clock edge; line changes are made right after negedges.
  task automatic send_frame(input logic [7:0] d, input bit pen, input bit pbit_good,
                            input bit stop_v, input int gap_bits);
    frame_t f;
    logic   pb;
    int     nbits;
    logic [10:0] line;
    pb = pbit_good ? ^d : ~(^d);
    parity_enable = pen;
    f.data = d;
    f.perr = pen && (pb != ^d);
    f.ferr = !stop_v;
    f.due  = cyc + 4 + CPB / 2 + CPB * (9 + (pen ? 1 : 0));
    exp_q.push_back(f);
    line = '0;
    line[8:1] = d;
    if (pen) begin
      line[9]  = pb;
      line[10] = stop_v;
      nbits = 11;
    end else begin
      line[9] = stop_v;
      nbits = 10;
    end
    for (int i = 0; i < nbits; i++) begin
      rx_pin = line[i];
      repeat (CPB) @(negedge clk);
    end
    if (gap_bits > 0) begin
      rx_pin = 1'b1;
      repeat (gap_bits * CPB) @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
    check({tag, "_data_ready"}, {31'd0, data_ready}, 32'd0);
    check({tag, "_parity_err"}, {31'd0, parity_err}, 32'd0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_rx_busy"}, {31'd0, rx_busy}, 32'd0);
  endtask

  initial begin
    int p0;
    int waited;
    logic [7:0] rb;
    logic [9:0] abort_line;
    reset = 1'b1;
    rx_pin = 1'b1;
    parity_enable = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    p0 = pulse_cnt;
    send_frame(8'hD3, 1'b0, 1'b1, 1'b1, 2);
    check("d3_pulses", pulse_cnt - p0, 32'd1);
    check("d3_data", {24'd0, rx_data}, 32'hD3);

    p0 = pulse_cnt;
    send_frame(8'hD3, 1'b1, 1'b1, 1'b1, 2);
    send_frame(8'hD3, 1'b1, 1'b0, 1'b1, 2);
    check("parity_pulses", pulse_cnt - p0, 32'd2);
    check("parity_bad_flag", {31'd0, parity_err}, 32'd1);

    p0 = pulse_cnt;
    send_frame(8'h55, 1'b0, 1'b1, 1'b0, 0);
    repeat (40 * CPB) @(negedge clk);
    check("break_busy_low_line", {31'd0, rx_busy}, 32'd1);
    check("break_pulses", pulse_cnt - p0, 32'd1);
    check("break_frame_err", {31'd0, frame_err}, 32'd1);
    rx_pin = 1'b1;
    repeat (4) @(negedge clk);
    check("break_busy_released", {31'd0, rx_busy}, 32'd0);
    repeat (2 * CPB) @(negedge clk);

    p0 = pulse_cnt;
    rx_pin = 1'b0;
    repeat (3) @(negedge clk);
    rx_pin = 1'b1;
    repeat (1) @(negedge clk);
    check("glitch_busy_seen", {31'd0, rx_busy}, 32'd1);
    repeat (CPB / 2 + 3 - 4) @(negedge clk);
    check("glitch_busy_cleared", {31'd0, rx_busy}, 32'd0);
    repeat (3 * CPB) @(negedge clk);
    check("glitch_pulses", pulse_cnt - p0, 32'd0);

    // 8'h0F: line stays low from data bit 4 to the stop bit, so no new edge follows the reset.
    p0 = pulse_cnt;
    abort_line = {1'b1, 8'h0F, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < CPB; j++) begin
        rx_pin = abort_line[i];
        if (i == 5 && j == 8) reset = 1'b1;
        if (i == 5 && j == 10) reset = 1'b0;
        if (i == 5 && j == 9) check_reset_outputs("midreset");
        @(negedge clk);
      end
    end
    rx_pin = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("midreset_pulses", pulse_cnt - p0, 32'd0);
    check("midreset_busy", {31'd0, rx_busy}, 32'd0);
    p0 = pulse_cnt;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 2);
    check("a5_pulses", pulse_cnt - p0, 32'd1);
    check("a5_data", {24'd0, rx_data}, 32'hA5);

    p0 = pulse_cnt;
    send_frame(8'h00, 1'b0, 1'b1, 1'b1, 0);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b1, 2);
    check("b2b_pulses", pulse_cnt - p0, 32'd2);
    check("b2b_last", {24'd0, rx_data}, 32'hFF);

    p0 = pulse_cnt;
    for (int k = 0; k < 24; k++) begin
      bit pen, pgood, stop_v;
      int gap;
      rb     = 8'($urandom_range(0, 255));
      pen    = 1'($urandom_range(0, 1));
      pgood  = 1'($urandom_range(0, 1));
      stop_v = ($urandom_range(0, 7) != 0);
      gap    = $urandom_range(0, 2);
      if (!stop_v && gap == 0) gap = 1;
      send_frame(rb, pen, pgood, stop_v, gap);
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("drain_queue", exp_q.size(), 32'd0);
    repeat (2 * CPB) @(negedge clk);
    check("random_pulses", pulse_cnt - p0, 32'd24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
